fetch_unit: RTL
===============

# fetch_unit

Instruction fetch sequencer for the single-issue processor: holds the PC, fetches words from instruction memory over a req/ack handshake with arbitrary wait states, and presents each instruction with pre-split fields (opcode, shamt, ALUop, registers, immediate) to the control decoder through a valid/ready handshake. It accepts branch/jump redirects from execute and discards wrong-path fetches in flight.

## Interface
Parameters:
- PC_W, 12, PC / imem address width (word addressed)
- CNT_W, 16, width of delivered-instruction counter

Ports:
- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  request strobe, high exactly one cycle per fetch
- imem_addr  out  PC_W  fetch address, valid while imem_req high
- imem_ack  in  1  read data valid; sampled only in WAIT/DRAIN
- imem_rdata  in  32  instruction word, valid with imem_ack
- insn_valid  out  1  output register holds a deliverable instruction
- insn_ready  in  1  decoder accepts this cycle
- insn  out  32  raw instruction word
- insn_pc  out  PC_W  address the instruction was fetched from
- opcode  out  5  insn[31:27]
- rd, rs, rt  out  5 each  insn[26:22], insn[21:17], insn[16:12]
- shamt  out  5  insn[11:7]
- ALUop  out  5  insn[6:2]
- imm  out  17  insn[16:0]
- redirect_en  in  1  branch/jump taken
- redirect_pc  in  PC_W  target address
- deliver_cnt  out  CNT_W  count of completed transfers, wraps mod 2^CNT_W

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN, FULL.
- IDLE: entered by reset; next cycle -> ISSUE.
- ISSUE: imem_req=1, imem_addr=pc; -> WAIT.
- WAIT: on imem_ack, capture imem_rdata into insn, insn_pc<=pc, insn_valid<=1, pc<=pc+1 (mod 2^PC_W); -> FULL. No ack: stay.
- FULL: transfer = insn_valid & insn_ready & ~redirect_en. On transfer: insn_valid<=0, deliver_cnt+1, -> ISSUE. Else hold all outputs stable.
- Redirect (priority over everything except reset), any state: pc<=redirect_pc, insn_valid<=0, no transfer counted.
  - In WAIT without ack: -> DRAIN. In WAIT with ack same cycle: data discarded, -> ISSUE.
  - In DRAIN: stay DRAIN, pc updated again (last redirect wins).
  - In IDLE/ISSUE/FULL: -> ISSUE. A redirect in ISSUE does not cancel the strobe already issued that cycle; state becomes DRAIN instead so its ack is discarded.
- DRAIN: wait for imem_ack, discard data, pc unchanged; -> ISSUE.
- imem_ack outside WAIT/DRAIN is ignored.
- Field outputs are pure slices of the insn register; they are stable whenever insn_valid is high.

## Timing
- Reset values: state IDLE, pc 0, imem_req 0, imem_addr 0, insn_valid 0, insn 0, insn_pc 0, all field outputs 0, deliver_cnt 0.
- Reset asserted mid-fetch: everything returns to reset values next edge; an outstanding ack arriving later is ignored (lands in IDLE/ISSUE).
- Zero-wait memory (ack the cycle after req): reset released at edge 0 -> ISSUE cycle 1 -> ack cycle 2 -> insn_valid high cycle 3.
- Steady-state throughput with zero-wait memory and insn_ready held high: one instruction per 3 cycles.
- Memory must not ack in the same cycle as req; fetch is non-overlapped (one outstanding request max).
- insn_valid never drops without a transfer, redirect or reset.

## Structure
- Shared package: state encoding, instruction field bit positions (opcode, rd, rs, rt, shamt, ALUop, imm), default PC_W.
- One sub-module: insn_fields, combinational splitter from 32-bit word to field outputs, reusable by the decoder bench.
- PC register, FSM and counter stay in fetch_unit.

## Test plan
- Reset, zero-wait memory returning word 0x28000005 at addr 0, ready high -> insn_valid at cycle 3, opcode=5, imm=5, insn_pc=0, deliver_cnt=1 after transfer.
- 4-cycle wait states, insn_ready low for 5 cycles in FULL -> imem_req stays low, insn/insn_pc stable, single transfer when ready rises.
- Redirect to 0x100 while in WAIT, ack 2 cycles later with 0xDEADBEEF -> data discarded, next imem_addr=0x100, insn_valid never shows 0xDEADBEEF.
- redirect_en and insn_ready high together in FULL -> no transfer, deliver_cnt unchanged, next fetch from redirect_pc.
- pc at 0xFFF, fetch completes -> pc wraps to 0x000; deliver_cnt preset near 0xFFFF wraps to 0.
- Reset asserted in WAIT, ack arrives the following cycle -> ignored; fetch restarts from addr 0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared definitions for the instruction fetch sequencer.
// Holds the fetch FSM state encoding, the bit positions of every
// instruction field, and the default PC / instruction-memory address width.
package fetch_unit_pkg;

  localparam int PC_W_DEF = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FULL  = 3'd4
  } fetch_state_e;

  // Instruction field bit positions (inclusive hi/lo).
  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 27;
  localparam int RD_HI    = 26;
  localparam int RD_LO    = 22;
  localparam int RS_HI    = 21;
  localparam int RS_LO    = 17;
  localparam int RT_HI    = 16;
  localparam int RT_LO    = 12;
  localparam int SHAMT_HI = 11;
  localparam int SHAMT_LO = 7;
  localparam int ALUOP_HI = 6;
  localparam int ALUOP_LO = 2;
  localparam int IMM_HI   = 16;
  localparam int IMM_LO   = 0;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the instruction-memory req/ack bus and the
// instruction valid/ready output bus of the fetch unit.
//   master : fetch unit side (drives imem_req/imem_addr and instruction outputs)
//   slave  : memory + decoder side (drives imem_ack/imem_rdata and insn_ready)
// Signals:
//   imem_req, imem_addr[PC_W], imem_ack, imem_rdata[32]
//   insn_valid, insn_ready, insn[32], insn_pc[PC_W]
//   opcode, rd, rs, rt, shamt, ALUop [5 each], imm[17]
interface fetch_unit_if
  import fetch_unit_pkg::*;
  #(parameter int PC_W = PC_W_DEF);

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  logic            insn_valid;
  logic            insn_ready;
  logic [31:0]     insn;
  logic [PC_W-1:0] insn_pc;
  logic [4:0]      opcode;
  logic [4:0]      rd;
  logic [4:0]      rs;
  logic [4:0]      rt;
  logic [4:0]      shamt;
  logic [4:0]      ALUop;
  logic [16:0]     imm;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output insn_valid, insn, insn_pc,
    output opcode, rd, rs, rt, shamt, ALUop, imm,
    input  insn_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  insn_valid, insn, insn_pc,
    input  opcode, rd, rs, rt, shamt, ALUop, imm,
    output insn_ready
  );

endinterface

// File: rtl/fetch_unit_insn_fields.sv
// fetch_unit_insn_fields: combinational splitter from a 32-bit instruction
// word to its decoder fields. Reusable wherever the field layout is needed.
// Ports:
//   insn_i     in  32  instruction word
//   opcode_o .. alu_op_o  out 5 each, imm_o out 17
module fetch_unit_insn_fields
  import fetch_unit_pkg::*;
(
  input  logic [31:0] insn_i,
  output logic [4:0]  opcode_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  shamt_o,
  output logic [4:0]  alu_op_o,
  output logic [16:0] imm_o
);

  assign opcode_o = insn_i[OPC_HI:OPC_LO];
  assign rd_o     = insn_i[RD_HI:RD_LO];
  assign rs_o     = insn_i[RS_HI:RS_LO];
  assign rt_o     = insn_i[RT_HI:RT_LO];
  assign shamt_o  = insn_i[SHAMT_HI:SHAMT_LO];
  assign alu_op_o = insn_i[ALUOP_HI:ALUOP_LO];
  assign imm_o    = insn_i[IMM_HI:IMM_LO];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer. Holds the PC, fetches one word at a
// time from instruction memory (req/ack, arbitrary wait states), presents it
// with pre-split fields on a valid/ready bus and takes branch/jump redirects,
// discarding any wrong-path fetch still in flight.
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   bus (master)        imem req/ack bus and instruction valid/ready bus
//   redirect_en/_pc     taken branch/jump and its target
//   deliver_cnt[CNT_W]  completed transfers, wraps
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  fetch_unit_if.master     bus,
  input  logic             redirect_en,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] deliver_cnt
);

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [31:0]      insn_q, insn_d;
  logic [PC_W-1:0]  insn_pc_q, insn_pc_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             transfer_s;

  logic [4:0]  opcode_s, rd_s, rs_s, rt_s, shamt_s, alu_op_s;
  logic [16:0] imm_s;

  assign transfer_s = valid_q & bus.insn_ready & ~redirect_en;

  // Next-state and datapath update for the fetch FSM.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    insn_d    = insn_q;
    insn_pc_d = insn_pc_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (redirect_en) begin
          pc_d = redirect_pc;
        end else begin
          pc_d = pc_q;
        end
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        // The strobe already left this cycle; a redirect must drain its ack.
        if (redirect_en) begin
          pc_d    = redirect_pc;
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_en) begin
          pc_d    = redirect_pc;
          state_d = bus.imem_ack ? ST_ISSUE : ST_DRAIN;
        end else if (bus.imem_ack) begin
          insn_d    = bus.imem_rdata;
          insn_pc_d = pc_q;
          valid_d   = 1'b1;
          pc_d      = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
          state_d   = ST_FULL;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        // Last redirect wins; an ack always retires the outstanding request
        // so the FSM cannot wait for an ack that will never come.
        if (redirect_en) begin
          pc_d = redirect_pc;
        end else begin
          pc_d = pc_q;
        end
        state_d = bus.imem_ack ? ST_ISSUE : ST_DRAIN;
      end
      ST_FULL: begin
        if (redirect_en) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
          state_d = ST_ISSUE;
        end else if (transfer_s) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State, PC, instruction and counter registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      insn_q    <= 32'h0000_0000;
      insn_pc_q <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      insn_q    <= insn_d;
      insn_pc_q <= insn_pc_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
    end
  end

  fetch_unit_insn_fields u_fields (
    .insn_i   (insn_q),
    .opcode_o (opcode_s),
    .rd_o     (rd_s),
    .rs_o     (rs_s),
    .rt_o     (rt_s),
    .shamt_o  (shamt_s),
    .alu_op_o (alu_op_s),
    .imm_o    (imm_s)
  );

  // Request and address come straight from registered state.
  assign bus.imem_req   = (state_q == ST_ISSUE);
  assign bus.imem_addr  = pc_q;
  assign bus.insn_valid = valid_q;
  assign bus.insn       = insn_q;
  assign bus.insn_pc    = insn_pc_q;
  assign bus.opcode     = opcode_s;
  assign bus.rd         = rd_s;
  assign bus.rs         = rs_s;
  assign bus.rt         = rt_s;
  assign bus.shamt      = shamt_s;
  assign bus.ALUop      = alu_op_s;
  assign bus.imm        = imm_s;
  assign deliver_cnt    = cnt_q;

endmodule
